// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the packed-BCD serial adder.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int BCD_CORR    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder: sum, decimal carry and invalid-nibble flag.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a_d,
  input  logic [BCD_DIGIT_W-1:0] b_d,
  input  logic                   c_in,
  output logic [BCD_DIGIT_W-1:0] d,
  output logic                   c_out,
  output logic                   bad
);

  logic [BCD_DIGIT_W:0] s;
  logic [BCD_DIGIT_W:0] s_corr;

  assign s      = {1'b0, a_d} + {1'b0, b_d} + {{BCD_DIGIT_W{1'b0}}, c_in};
  assign s_corr = s + (BCD_DIGIT_W + 1)'(BCD_CORR);

  // Out-of-range nibbles take the same correction path; the wrap is intentional.
  assign c_out = (s > (BCD_DIGIT_W + 1)'(BCD_MAX));
  assign d     = c_out ? s_corr[BCD_DIGIT_W-1:0] : s[BCD_DIGIT_W-1:0];
  assign bad   = (a_d > BCD_DIGIT_W'(BCD_MAX)) | (b_d > BCD_DIGIT_W'(BCD_MAX));

endmodule : bcd_digit_adder

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder: one digit per clock through a shared digit adder,
// valid/ready handshakes on both the operand and the result side.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
  input  logic                          cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
  output logic                          cout,
  output logic                          err
);

  localparam int W     = BCD_DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx;
  logic [W-1:0]             a_q, b_q;
  logic [W-1:0]             sum_q;
  logic                     carry_q, cout_q, err_q;
  logic [BCD_DIGIT_W-1:0]   dig;
  logic                     dig_c, dig_bad;
  logic                     last;
  logic                     accept;

  assign last      = (idx == IDX_W'(DIGITS - 1));
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  bcd_digit_adder u_digit (
    .a_d   (a_q[BCD_DIGIT_W-1:0]),
    .b_d   (b_q[BCD_DIGIT_W-1:0]),
    .c_in  (carry_q),
    .d     (dig),
    .c_out (dig_c),
    .bad   (dig_bad)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it unassigned.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: operand shifters carry no reset; they are always loaded on acceptance
  // before being read, so resetting them would only add fan-out on rst.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_q <= a;
      b_q <= b;
    end else if (state_q == RUN) begin
      a_q <= a_q >> BCD_DIGIT_W;
      b_q <= b_q >> BCD_DIGIT_W;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      idx     <= '0;
      carry_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            idx     <= '0;
            carry_q <= cin;
          end
        end
        RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) sum_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] <= dig;
          end
          carry_q <= dig_c;
          err_q   <= err_q | dig_bad;
          if (last) cout_q <= dig_c;
          else      idx    <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule : bcd_serial_adder

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4): directed table, corner
// sequences and randomized operands against a decimal reference model.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int checks   = 0;
  int failures = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit all_valid(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++) if (((v >> (4 * i)) & 16'hF) > 9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int to_dec(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'((v >> (4 * i)) & 16'hF);
    return r;
  endfunction

  function automatic logic [W-1:0] from_dec(input int n);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | W'((n % 10) << (4 * i));
      n = n / 10;
    end
    return r;
  endfunction

  // Reference: plain decimal arithmetic for valid BCD, digit-wise rule otherwise.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                       output logic [W-1:0] ms, output logic mco, output logic me);
    int lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    me = !(all_valid(ma) && all_valid(mb));
    if (!me) begin
      int total = to_dec(ma) + to_dec(mb) + int'(mc);
      ms  = from_dec(total % lim);
      mco = (total >= lim);
    end else begin
      int c = int'(mc);
      ms = '0;
      for (int i = 0; i < DIGITS; i++) begin
        int t = int'((ma >> (4 * i)) & 16'hF) + int'((mb >> (4 * i)) & 16'hF) + c;
        if (t > 9) begin t = t + 6; c = 1; end
        else c = 0;
        ms = ms | W'((t % 16) << (4 * i));
      end
      mco = c[0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        output logic [W-1:0] rs, output logic rc, output logic re,
                        output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    check("accept_ready", 32'(in_ready), 32'd1);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    rs = sum; rc = cout; re = err;
    out_ready = 1'b1;
    tick();
  endtask

  vec_t         vecs[7];
  logic [W-1:0] rs, es;
  logic         rc, re, ec, ee;
  int           lat;

  initial begin
    vecs[0] = '{"basic",       16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{"chain_9999",  16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"all_nines",   16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[3] = '{"invalid",     16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1};
    vecs[4] = '{"small",       16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0};
    vecs[5] = '{"cin_only",    16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[6] = '{"top_carry",   16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, re, lat);
      check({vecs[i].name, "_sum"},  32'(rs),  32'(vecs[i].exp_sum));
      check({vecs[i].name, "_cout"}, 32'(rc),  32'(vecs[i].exp_cout));
      check({vecs[i].name, "_err"},  32'(re),  32'(vecs[i].exp_err));
      check({vecs[i].name, "_lat"},  32'(lat), 32'(DIGITS));
    end

    // Backpressure, with ignored operand pulses during RUN and DONE
    out_ready = 1'b0;
    a = 16'h1234; b = 16'h5678; cin = 1'b0; in_valid = 1'b1;
    tick();
    a = 16'h9999; b = 16'h9999;
    lat = 0;
    while (!out_valid && lat < 50) begin
      check("bp_run_in_ready", 32'(in_ready), 32'd0);
      tick(); lat++;
    end
    check("bp_lat", 32'(lat), 32'(DIGITS));
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum",       32'(sum),       32'h6912);
      check("bp_cout",      32'(cout),      32'd0);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready),  32'd1);
    check("bp_held_sum",      32'(sum),       32'h6912);

    // Back-to-back with in_valid held high
    begin
      int           acc_n = 0;
      int           res_n = 0;
      int           acc_t[2];
      logic [W-1:0] r_sum[2];
      logic         r_err[2];
      logic         fire, ov;
      acc_t = '{0, 0};
      a = 16'h00A0; b = 16'h0000; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 40 && res_n < 2; k++) begin
        fire = in_valid && in_ready;
        ov   = out_valid;
        if (ov) begin r_sum[res_n] = sum; r_err[res_n] = err; res_n++; end
        tick();
        if (fire) begin
          acc_t[acc_n] = k; acc_n++;
          if (acc_n == 1) begin a = 16'h0005; b = 16'h0004; end
          else in_valid = 1'b0;
        end
      end
      check("b2b_accepts", 32'(acc_n), 32'd2);
      check("b2b_results", 32'(res_n), 32'd2);
      check("b2b_spacing", 32'(acc_t[1] - acc_t[0]), 32'(DIGITS + 2));
      if (res_n == 2) begin
        check("b2b_first_sum",  32'(r_sum[0]), 32'h0100);
        check("b2b_first_err",  32'(r_err[0]), 32'd1);
        check("b2b_second_sum", 32'(r_sum[1]), 32'h0009);
        check("b2b_second_err", 32'(r_err[1]), 32'd0);
      end
      in_valid = 1'b0;
      tick();
    end

    // Reset two cycles into RUN
    a = 16'h1234; b = 16'h5678; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("midrun_partial_sum", 32'(sum), 32'h0012);
    rst = 1'b1;
    #1;
    check("midrun_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("midrun_out_valid", 32'(out_valid), 32'd0);
    check("midrun_sum",       32'(sum),       32'd0);
    check("midrun_cout",      32'(cout),      32'd0);
    check("midrun_err",       32'(err),       32'd0);
    check("midrun_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    check("midrun_release_ready", 32'(in_ready), 32'd1);
    run_op(16'h0001, 16'h0001, 1'b0, rs, rc, re, lat);
    check("after_rst_sum", 32'(rs),  32'h0002);
    check("after_rst_lat", 32'(lat), 32'(DIGITS));

    // Randomized operands against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      logic         rcin;
      if (n % 4 == 3) begin
        ra = W'($urandom); rb = W'($urandom);
      end else begin
        ra = from_dec(int'($urandom_range(0, 9999)));
        rb = from_dec(int'($urandom_range(0, 9999)));
      end
      rcin = 1'($urandom);
      model(ra, rb, rcin, es, ec, ee);
      run_op(ra, rb, rcin, rs, rc, re, lat);
      check("rand_sum",  32'(rs),  32'(es));
      check("rand_cout", 32'(rc),  32'(ec));
      check("rand_err",  32'(re),  32'(ee));
      check("rand_lat",  32'(lat), 32'(DIGITS));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bcd_serial_adder
